// File: rtl/com_send_if.sv
// -----------------------------------------------------------------------------
// com_send_if
//   Byte-wide link between the frame transmitter and the link transmitter.
//   tx_data  : byte being offered
//   tx_valid : tx_data is valid
//   tx_ready : link transmitter accepts the byte this cycle
//   A byte transfers on every cycle where tx_valid & tx_ready.
//   master : frame source (drives data/valid)
//   slave  : link transmitter (drives ready)
// -----------------------------------------------------------------------------
interface com_send_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/com_send.sv
// -----------------------------------------------------------------------------
// com_send
//   Framing transmitter. On a send request it emits
//     SYNC0, SYNC1, {btype, dlen[11:8]}, dlen[7:0], dlen payload bytes, checksum
//   The payload is read from the shared sample RAM starting at addr_init
//   (address wraps mod 4096). The checksum is the mod-256 sum of the header
//   type/length bytes and all payload bytes. A byte left unaccepted for
//   TX_TIMEOUT stall cycles aborts the frame with a one-cycle fd_txer pulse;
//   a still-pending request then restarts the whole frame.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-low reset
//   fs_send    : send request level (held until done/error)
//   fd_send    : frame complete, held until fs_send drops
//   fd_txer    : one-cycle pulse, frame aborted on timeout
//   btype      : packet type, sampled at frame start
//   addr_init  : first payload RAM address, sampled at frame start
//   dlen       : payload length in bytes, sampled at frame start
//   ram_addr   : RAM read address (RAM data returns one cycle later)
//   ram_rxd    : RAM read data
//   tx         : byte link (master side)
// -----------------------------------------------------------------------------
module com_send #(
   parameter logic [15:0] TX_TIMEOUT = 16'd50000,
   parameter logic [7:0]  SYNC0      = 8'h55,
   parameter logic [7:0]  SYNC1      = 8'hAA
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fs_send,
   output logic              fd_send,
   output logic              fd_txer,
   input  logic [3:0]        btype,
   input  logic [11:0]       addr_init,
   input  logic [11:0]       dlen,
   output logic [11:0]       ram_addr,
   input  logic [7:0]        ram_rxd,
   com_send_if.master        tx
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HEAD  = 3'd1,
      RADDR = 3'd2,
      RWAIT = 3'd3,
      DATA  = 3'd4,
      SUM   = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t      state_reg, state_next;
   logic [3:0]  btype_reg, btype_next;
   logic [11:0] dlen_reg, dlen_next;
   logic [11:0] remain_reg, remain_next;   // payload bytes still to send
   logic [11:0] addr_reg, addr_next;       // doubles as ram_addr
   logic [1:0]  hcnt_reg, hcnt_next;       // header byte index
   logic [7:0]  sum_reg, sum_next;
   logic [15:0] tmo_reg, tmo_next;
   logic [7:0]  tx_data_reg, tx_data_next;
   logic        tx_valid_reg, tx_valid_next;
   logic        fd_send_reg, fd_send_next;
   logic        fd_txer_reg, fd_txer_next;

   logic        accept;
   logic        stall;
   logic        timeout_hit;
   logic [7:0]  sum_plus;

   // Header byte table, indexed by the header byte counter.
   function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                           input logic [3:0]  bt,
                                           input logic [11:0] len);
      case (idx)
         2'd0:    hdr_byte = SYNC0;
         2'd1:    hdr_byte = SYNC1;
         2'd2:    hdr_byte = {bt, len[11:8]};
         default: hdr_byte = len[7:0];
      endcase
   endfunction

   assign accept      = tx_valid_reg & tx.tx_ready;
   assign stall       = tx_valid_reg & ~tx.tx_ready;
   // Abort only if the byte is still refused in the cycle the limit is
   // reached; a late accept in that cycle wins.
   assign timeout_hit = stall & (tmo_reg == TX_TIMEOUT);
   // Running checksum including the byte currently on the link. Used both to
   // accumulate on accept and to present the checksum with no bubble.
   assign sum_plus    = sum_reg + tx_data_reg;

   // -------------------------------------------------------------------------
   // State / output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         btype_reg    <= 4'h0;
         dlen_reg     <= 12'h000;
         remain_reg   <= 12'h000;
         addr_reg     <= 12'h000;
         hcnt_reg     <= 2'd0;
         sum_reg      <= 8'h00;
         tmo_reg      <= 16'h0000;
         tx_data_reg  <= 8'h00;
         tx_valid_reg <= 1'b0;
         fd_send_reg  <= 1'b0;
         fd_txer_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         btype_reg    <= btype_next;
         dlen_reg     <= dlen_next;
         remain_reg   <= remain_next;
         addr_reg     <= addr_next;
         hcnt_reg     <= hcnt_next;
         sum_reg      <= sum_next;
         tmo_reg      <= tmo_next;
         tx_data_reg  <= tx_data_next;
         tx_valid_reg <= tx_valid_next;
         fd_send_reg  <= fd_send_next;
         fd_txer_reg  <= fd_txer_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      btype_next    = btype_reg;
      dlen_next     = dlen_reg;
      remain_next   = remain_reg;
      addr_next     = addr_reg;
      hcnt_next     = hcnt_reg;
      sum_next      = sum_reg;
      tx_data_next  = tx_data_reg;
      tx_valid_next = tx_valid_reg;
      fd_send_next  = fd_send_reg;
      fd_txer_next  = 1'b0;
      // Stall counter: counts refused cycles, clears on accept or when idle.
      tmo_next      = stall ? (tmo_reg + 16'd1) : 16'h0000;

      if (timeout_hit) begin
         state_next    = IDLE;
         tx_valid_next = 1'b0;
         fd_txer_next  = 1'b1;
         tmo_next      = 16'h0000;
      end else begin
         case (state_reg)
            IDLE: begin
               fd_send_next = 1'b0;
               if (fs_send) begin
                  btype_next  = btype;
                  dlen_next   = dlen;
                  remain_next = dlen;
                  addr_next   = addr_init;
                  hcnt_next   = 2'd0;
                  sum_next    = 8'h00;
                  state_next  = HEAD;
               end
            end

            HEAD: begin
               if (!tx_valid_reg) begin
                  tx_data_next  = hdr_byte(hcnt_reg, btype_reg, dlen_reg);
                  tx_valid_next = 1'b1;
               end else if (accept) begin
                  // Only the type/length bytes enter the checksum.
                  if (hcnt_reg[1]) begin
                     sum_next = sum_plus;
                  end
                  if (hcnt_reg == 2'd3) begin
                     hcnt_next = 2'd0;
                     if (dlen_reg != 12'h000) begin
                        tx_valid_next = 1'b0;
                        state_next    = RADDR;
                     end else begin
                        tx_data_next  = sum_plus;
                        state_next    = SUM;
                     end
                  end else begin
                     hcnt_next    = hcnt_reg + 2'd1;
                     tx_data_next = hdr_byte(hcnt_reg + 2'd1, btype_reg, dlen_reg);
                  end
               end
            end

            // ram_addr already carries the current address here; the RAM
            // answers during RWAIT.
            RADDR: begin
               state_next = RWAIT;
            end

            RWAIT: begin
               tx_data_next  = ram_rxd;
               tx_valid_next = 1'b1;
               state_next    = DATA;
            end

            DATA: begin
               if (accept) begin
                  sum_next    = sum_plus;
                  addr_next   = addr_reg + 12'd1;
                  remain_next = remain_reg - 12'd1;
                  if (remain_reg == 12'd1) begin
                     tx_data_next = sum_plus;
                     state_next   = SUM;
                  end else begin
                     tx_valid_next = 1'b0;
                     state_next    = RADDR;
                  end
               end
            end

            SUM: begin
               if (accept) begin
                  tx_valid_next = 1'b0;
                  fd_send_next  = 1'b1;
                  state_next    = DONE;
               end
            end

            DONE: begin
               // Wait for the request to drop so one request gives one frame.
               if (!fs_send) begin
                  fd_send_next = 1'b0;
                  state_next   = IDLE;
               end
            end

            default: begin
               tx_valid_next = 1'b0;
               fd_send_next  = 1'b0;
               state_next    = IDLE;
            end
         endcase
      end
   end

   assign fd_send     = fd_send_reg;
   assign fd_txer     = fd_txer_reg;
   assign ram_addr    = addr_reg;
   assign tx.tx_data  = tx_data_reg;
   assign tx.tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_com_send.sv
// -----------------------------------------------------------------------------
// tb_com_send
//   Table of frame requests applied in a loop; expected bytes are pushed into a
//   scoreboard queue at request time and popped on every link transfer.
//   Hand-written sequences cover timeout/retransmit and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_com_send;

   localparam logic [15:0] TMO = 16'd20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fs_send = 1'b0;
   logic        fd_send;
   logic        fd_txer;
   logic [3:0]  btype = 4'h0;
   logic [11:0] addr_init = 12'h000;
   logic [11:0] dlen = 12'h000;
   logic [11:0] ram_addr;
   logic [7:0]  ram_rxd = 8'h00;

   com_send_if tx_if ();

   com_send #(.TX_TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .fs_send   (fs_send),
      .fd_send   (fd_send),
      .fd_txer   (fd_txer),
      .btype     (btype),
      .addr_init (addr_init),
      .dlen      (dlen),
      .ram_addr  (ram_addr),
      .ram_rxd   (ram_rxd),
      .tx        (tx_if)
   );

   always #5 clk = ~clk;

   // Sample RAM with registered read
   logic [7:0] mem [0:4095];
   always @(posedge clk) ram_rxd <= mem[ram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_b;
   int         acc_cnt = 0;
   int         last_acc_cyc = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   int         ready_mode = 0;   // 0: always ready, 1: random, 2: man_ready
   logic       man_ready = 1'b1;
   int         zrun = 0;

   typedef struct {
      logic [3:0]  bt;
      logic [11:0] ai;
      logic [11:0] dl;
      int          mode;
      logic [7:0]  sum;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock: drive tx_ready after the edge, then monitor at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
      case (ready_mode)
         0: tx_if.tx_ready = 1'b1;
         1: begin
            if (zrun >= 4) tx_if.tx_ready = 1'b1;
            else           tx_if.tx_ready = 1'($urandom_range(0, 1));
            if (tx_if.tx_ready) zrun = 0;
            else                zrun++;
         end
         default: tx_if.tx_ready = man_ready;
      endcase
      @(negedge clk);
      if (rst) begin
         if (prev_stall && tx_if.tx_valid)
            chk("tx_data_hold", 32'(tx_if.tx_data), 32'(prev_data));
         if (tx_if.tx_valid && tx_if.tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)",
                        tx_if.tx_data, cyc);
            end else begin
               exp_b = exp_q.pop_front();
               chk("tx_byte", 32'(tx_if.tx_data), 32'(exp_b));
               $display("byte %02h expected %02h cycle %0d", tx_if.tx_data, exp_b, cyc);
            end
            acc_cnt++;
            last_acc_cyc = cyc;
         end
         prev_stall = tx_if.tx_valid & ~tx_if.tx_ready;
         prev_data  = tx_if.tx_data;
      end else begin
         prev_stall = 1'b0;
      end
   endtask

   task automatic push_frame(input logic [3:0] bt, input logic [11:0] ai,
                             input logic [11:0] dl, input logic [7:0] sum);
      logic [11:0] a;
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      exp_q.push_back({bt, dl[11:8]});
      exp_q.push_back(dl[7:0]);
      a = ai;
      for (int i = 0; i < int'(dl); i++) begin
         exp_q.push_back(mem[a]);
         a = a + 12'd1;
      end
      exp_q.push_back(sum);
   endtask

   task automatic wait_done(input logic [11:0] ai, input logic [11:0] dl,
                            input logic fast, input int first_cyc, input int base_acc);
      int lim;
      int k;
      lim = 12 * int'(dl) + 200;
      k = 0;
      while (!fd_send && k < lim) begin
         tick();
         k++;
      end
      if (!fd_send) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got fd_send 0 expected 1 within %0d cycles", lim);
         fs_send = 1'b0;
         return;
      end
      chk("fd_send_delay", 32'(cyc), 32'(last_acc_cyc + 1));
      chk("byte_count", 32'(acc_cnt - base_acc), 32'(int'(dl) + 5));
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("ram_addr_end", 32'(ram_addr), 32'(12'(ai + dl)));
      if (fast) chk("frame_cycles", 32'(last_acc_cyc - first_cyc), 32'(4 + 3 * int'(dl)));
      repeat (2) begin
         tick();
         chk("fd_send_held", 32'(fd_send), 32'd1);
      end
      fs_send = 1'b0;
      tick();
      chk("fd_send_fall", 32'(fd_send), 32'd0);
      $display("frame done type %0h addr %03h len %0d", btype, ai, dl);
   endtask

   task automatic run_frame(input vec_t v);
      int n;
      int first;
      int base;
      int k;
      btype      = v.bt;
      addr_init  = v.ai;
      dlen       = v.dl;
      ready_mode = v.mode;
      zrun       = 0;
      push_frame(v.bt, v.ai, v.dl, v.sum);
      base    = acc_cnt;
      fs_send = 1'b1;
      n       = cyc;
      k = 0;
      while (!tx_if.tx_valid && k < 10) begin
         tick();
         k++;
      end
      chk("start_latency", 32'(cyc), 32'(n + 2));
      first = cyc;
      // Inputs are sampled at frame start; changing them now must not matter.
      btype     = 4'($urandom);
      addr_init = 12'($urandom);
      dlen      = 12'($urandom);
      wait_done(v.ai, v.dl, v.mode == 0, first, base);
      ready_mode = 0;
      tick();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      int c;
      int t;
      int base;
      int first;
      int stalls;
      int seen;

      tx_if.tx_ready = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
      mem[12'hFCC] = 8'h12;
      mem[12'hFCD] = 8'h34;

      vecs[0] = '{4'h9, 12'hFCC, 12'h002, 0, 8'hD8};
      vecs[1] = '{4'hC, 12'h123, 12'h000, 0, 8'hC0};
      vecs[2] = '{4'hD, 12'h000, 12'h202, 0, 8'hD5};
      vecs[3] = '{4'h3, 12'hFFE, 12'h004, 0, 8'h32};
      vecs[4] = '{4'h9, 12'hFCC, 12'h002, 1, 8'hD8};
      vecs[5] = '{4'h5, 12'h010, 12'h003, 1, 8'h86};
      vecs[6] = '{4'h3, 12'hFFE, 12'h004, 1, 8'h32};

      // Reset values
      tick();
      tick();
      chk("rst_fd_send", 32'(fd_send), 32'd0);
      chk("rst_fd_txer", 32'(fd_txer), 32'd0);
      chk("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_if.tx_data), 32'h00);
      chk("rst_ram_addr", 32'(ram_addr), 32'h000);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) run_frame(vecs[i]);

      // Timeout after 3 bytes, request held -> full retransmit
      btype      = 4'h9;
      addr_init  = 12'hFCC;
      dlen       = 12'h002;
      ready_mode = 2;
      man_ready  = 1'b1;
      push_frame(4'h9, 12'hFCC, 12'h002, 8'hD8);
      base    = acc_cnt;
      fs_send = 1'b1;
      k = 0;
      while (acc_cnt < base + 3 && k < 20) begin
         tick();
         k++;
      end
      man_ready = 1'b0;
      c = cyc;
      stalls = 0;
      k = 0;
      while (!fd_txer && k < 100) begin
         tick();
         if (tx_if.tx_valid && !tx_if.tx_ready) stalls++;
         k++;
      end
      chk("txer_seen", 32'(fd_txer), 32'd1);
      chk("txer_cycle", 32'(cyc), 32'(c + int'(TMO) + 2));
      chk("stall_cycles", 32'(stalls), 32'(int'(TMO) + 1));
      chk("valid_at_txer", 32'(tx_if.tx_valid), 32'd0);
      chk("sb_left_at_abort", 32'(exp_q.size()), 32'd4);
      $display("timeout abort cycle %0d stalls %0d", cyc, stalls);
      t = cyc;
      exp_q.delete();
      push_frame(4'h9, 12'hFCC, 12'h002, 8'hD8);
      base = acc_cnt;
      man_ready = 1'b1;
      tick();
      chk("txer_pulse", 32'(fd_txer), 32'd0);
      k = 0;
      while (!tx_if.tx_valid && k < 10) begin
         tick();
         k++;
      end
      chk("restart_latency", 32'(cyc), 32'(t + 2));
      first = cyc;
      wait_done(12'hFCC, 12'h002, 1'b1, first, base);
      ready_mode = 0;
      tick();

      // Reset mid-payload
      btype     = 4'hD;
      addr_init = 12'h000;
      dlen      = 12'h202;
      push_frame(4'hD, 12'h000, 12'h202, 8'hD5);
      base    = acc_cnt;
      fs_send = 1'b1;
      k = 0;
      while (acc_cnt < base + 10 && k < 200) begin
         tick();
         k++;
      end
      #2;
      rst = 1'b0;
      #1;
      chk("arst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
      chk("arst_tx_data", 32'(tx_if.tx_data), 32'h00);
      chk("arst_ram_addr", 32'(ram_addr), 32'h000);
      chk("arst_fd_send", 32'(fd_send), 32'd0);
      $display("reset asserted mid-payload at cycle %0d", cyc);
      fs_send = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst = 1'b1;
      seen = 0;
      repeat (6) begin
         tick();
         if (tx_if.tx_valid || fd_send) seen++;
      end
      chk("idle_after_reset", 32'(seen), 32'd0);
      run_frame(vecs[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/com_send.md
# com_send

Framing transmitter between the console sequencer and the byte-wide link transmitter. On a send request it emits a fixed frame: sync bytes, packet-type/length header, a payload read from the shared sample RAM, and an 8-bit checksum. It reports completion or a transmit timeout back to the console. It consumes the console's `send_btype`, `ram_addr_init` and `ram_dlen` outputs and answers its `fs_com_send` with `fd_com_send`/`fd_com_txer`.

## Interface
- `TX_TIMEOUT`, default 16'd50000: number of cycles `tx_valid` may stay high without `tx_ready` before the frame is aborted.
- `SYNC0`, default 8'h55: first sync byte.
- `SYNC1`, default 8'hAA: second sync byte.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-low reset.
- `fs_send`  in  1  send request level from the console, held until done/error.
- `fd_send`  out  1  frame complete; held until `fs_send` goes low.
- `fd_txer`  out  1  one-cycle pulse; frame aborted on timeout.
- `btype`  in  4  packet type, sampled at frame start.
- `addr_init`  in  12  first RAM byte address, sampled at frame start.
- `dlen`  in  12  payload length in bytes (0..4095), sampled at frame start.
- `ram_addr`  out  12  RAM read address.
- `ram_rxd`  in  8  RAM read data, valid 1 cycle after `ram_addr`.
- `tx_data`  out  8  byte to link transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts the byte this cycle.

## Operation
- Frame order:
  - `SYNC0`, `SYNC1`
  - `{btype, dlen[11:8]}`, `dlen[7:0]`
  - `dlen` payload bytes from RAM `addr_init`, `addr_init+1`, …
  - checksum.
- Frame length is `dlen + 5` bytes.
- Checksum: 8-bit sum, mod 256, of every byte from the type/length byte through the last payload byte. The sync bytes are excluded.
- RAM addresses increment mod 4096; wrap from 12'hFFF to 12'h000 is legal.
- With `dlen = 0` the payload is skipped and the frame is 5 bytes.
- FSM states:
  - IDLE: on `fs_send` = 1, latch `btype`, `addr_init` and `dlen`; clear the checksum and byte counter; go to HEAD.
  - HEAD: present the 4 header bytes in sequence, advancing on each `tx_valid & tx_ready`. After the 4th byte, go to RADDR if `dlen` ≠ 0, else to SUM.
  - RADDR: drive `ram_addr` = current address; go to RWAIT.
  - RWAIT: go to DATA, capturing `ram_rxd` into `tx_data`.
  - DATA: on accept, add the byte to the checksum, increment the address and decrement the remaining count. Go to RADDR, or to SUM after the last byte.
  - SUM: present the checksum; on accept go to DONE.
  - DONE: `fd_send` = 1; go to IDLE when `fs_send` = 0.
- Timeout:
  - A 16-bit counter runs while `tx_valid & ~tx_ready` and clears on every accept.
  - On reaching `TX_TIMEOUT`: pulse `fd_txer` for one cycle, drop `tx_valid`, go to IDLE.
  - If `fs_send` is still high, IDLE restarts the whole frame (retransmit), re-sampling its inputs.
- `fs_send` falling mid-frame is ignored. The frame completes, and DONE exits on the next cycle.
- `fs_send` must be low on leaving DONE, so one request never produces two frames.

## Timing
- Reset values: `fd_send` 0, `fd_txer` 0, `tx_valid` 0, `tx_data` 8'h00, `ram_addr` 12'h000, state IDLE, counters 0.
- All outputs are registered.
- `fs_send` rising at cycle n gives first `tx_valid` at n+2 (IDLE→HEAD register stage).
- `tx_data` is stable while `tx_valid` is high without `tx_ready`. A byte transfers exactly on cycles where `tx_valid & tx_ready`.
- Header and checksum bytes: 1 byte per cycle with `tx_ready` held high.
- Payload: 1 byte per 3 cycles (RADDR, RWAIT, DATA) with `tx_ready` held high.
- Last checksum accept at cycle m gives `fd_send` = 1 at m+1.
- Timeout: `fd_txer` is high exactly on the cycle after the counter reaches `TX_TIMEOUT`. `tx_valid` is 0 in that same cycle.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). No partial frame resumes after release.

## Test plan
- Type 9, length 2, RAM[FCC]=8'h12, RAM[FCD]=8'h34, `tx_ready`=1:
  - bytes are 55 AA 90 02 12 34 D8;
  - `fd_send` rises 1 cycle after D8 and falls 1 cycle after `fs_send` falls.
- Length 0, type C: bytes 55 AA C0 00 C0; no RAM reads are issued.
- Type D, length 12'h202 from 12'h000, RAM[i] = i[7:0]:
  - 519 bytes;
  - checksum = (8'hD2 + 8'h02 + sum of payload) mod 256;
  - payload occupies 3 cycles per byte.
- `addr_init` = 12'hFFE, `dlen` = 4: reads FFE, FFF, 000, 001 in order.
- `tx_ready` random 50%: byte sequence identical to the `tx_ready`=1 case; `tx_data` never changes while unaccepted.
- `TX_TIMEOUT` = 20, `tx_ready` stuck 0 after 3 bytes:
  - `fd_txer` is a single pulse;
  - `fs_send` held high → the frame restarts from 55 once `tx_ready` returns;
  - reset asserted mid-payload → `tx_valid` drops at once and the FSM is in IDLE after release.
